memory_arbiter: RTL and testbench

//  Sequences the single shared RAM port between instruction-fetch and data

---
 rtl/memory_arbiter_if.sv | 75 +++++++
 rtl/memory_arbiter.sv | 170 +++++++++++++++++
 tb/tb_memory_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// ---------------------------------------------------------------------------
// memory_arbiter_if
// Bundles the requester-side and RAM-side signals of the shared RAM port so
// that the arbiter and its environment connect through one port.
//
// Parameter
//   WORD_W    width of addresses, store data and load data
//
// Signals (direction given from the arbiter's side, modport slave)
//   iREN      in   instruction read request
//   iaddr     in   instruction address
//   iwait     out  1 = instruction access not complete
//   iload     out  instruction read data
//   dREN      in   data read request
//   dWEN      in   data write request
//   daddr     in   data address
//   dstore    in   data write value
//   dwait     out  1 = data access not complete
//   dload     out  data read data
//   ramREN    out  RAM read enable
//   ramWEN    out  RAM write enable
//   ramaddr   out  RAM address
//   ramstore  out  RAM write data
//   ramload   in   RAM read data
//   ramstate  in   RAM status: FREE=0 BUSY=1 ACCESS=2 ERROR=3
//
// Modports
//   slave   the arbiter
//   master  the environment (request unit / caches and RAM model)
// ---------------------------------------------------------------------------
interface memory_arbiter_if #(
  parameter int unsigned WORD_W = 32
);

  // Instruction requester
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;

  // Data requester
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dwait;
  logic [WORD_W-1:0] dload;

  // RAM port
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic [1:0]        ramstate;

  modport slave (
    input  iREN, iaddr,
    input  dREN, dWEN, daddr, dstore,
    input  ramload, ramstate,
    output iwait, iload,
    output dwait, dload,
    output ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr,
    output dREN, dWEN, daddr, dstore,
    output ramload, ramstate,
    input  iwait, iload,
    input  dwait, dload,
    input  ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
// Shares the single RAM port between the instruction-fetch and data
// requesters. A registered grant (IDLE / DGRANT / IGRANT) decides who owns
// the port; data has priority. RAM control, address/store routing and the
// per-requester wait signals are decoded from the grant and the live
// requester/RAM inputs, so a completion (ramstate == ACCESS) or a withdrawn
// request takes effect in the same cycle. Every access is followed by one
// IDLE bubble cycle in which the next grant is decided.
//
// Parameters
//   WORD_W       width of address, store and load data
//   MAX_DSTREAK  consecutive data grants allowed while an ifetch waits
//                (only meaningful with MEM_ARB_FAIR_EN)
//
// Ports
//   CLK    in   clock, rising edge
//   nRST   in   asynchronous active-low reset
//   bus    memory_arbiter_if.slave: requester handshakes and RAM port
//
// Configuration macro
//   MEM_ARB_FAIR_EN  when defined, a saturating counter of data grants taken
//                    while an ifetch is pending forces an ifetch grant once
//                    it reaches MAX_DSTREAK. When undefined, data priority is
//                    strict and the ifetch side may starve.
// ---------------------------------------------------------------------------
module memory_arbiter #(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  memory_arbiter_if.slave   bus
);

  // Only the ACCESS encoding of ramstate changes behaviour; FREE, BUSY and
  // ERROR all mean "keep the grant and keep waiting".
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic   d_req;
  logic   ram_done;
  logic   fair_force_i;

  // A fairness limit of zero would hand every contested slot to the ifetch
  // side and turn the priority upside down.
  if (MAX_DSTREAK == 0) begin : g_cfg_check
    $error("memory_arbiter: MAX_DSTREAK must be at least 1");
  end

  assign d_req    = bus.dREN | bus.dWEN;
  assign ram_done = (bus.ramstate == RAM_ACCESS);

`ifdef MEM_ARB_FAIR_EN
  localparam int unsigned STREAK_W = $clog2(MAX_DSTREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

  logic [STREAK_W-1:0] dstreak_q;
  logic [STREAK_W-1:0] dstreak_d;

  // A waiting ifetch that has already watched MAX_DSTREAK data grants go by
  // takes the next slot regardless of pending data.
  assign fair_force_i = bus.iREN && (dstreak_q == STREAK_MAX);
`else
  assign fair_force_i = 1'b0;
`endif

  // Grant decision and port decode from the registered grant.
  always_comb begin
    state_d      = state_q;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = WORD_W'(0);
    bus.ramstore = WORD_W'(0);
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
`ifdef MEM_ARB_FAIR_EN
    dstreak_d    = dstreak_q;
`endif

    unique case (state_q)
      IDLE: begin
`ifdef MEM_ARB_FAIR_EN
        // Nobody is being starved once the ifetch side stops asking.
        if (!bus.iREN) begin
          dstreak_d = '0;
        end
`endif
        if (d_req && !fair_force_i) begin
          state_d = DGRANT;
`ifdef MEM_ARB_FAIR_EN
          if (bus.iREN && (dstreak_q != STREAK_MAX)) begin
            dstreak_d = dstreak_q + STREAK_W'(1);
          end
`endif
        end else if (bus.iREN) begin
          state_d = IGRANT;
`ifdef MEM_ARB_FAIR_EN
          dstreak_d = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      DGRANT: begin
        // Address and store data follow the requester live, not latched.
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        if (!d_req) begin
          // Withdrawn before completion: release the port, no done pulse.
          state_d = IDLE;
        end else begin
          // A write wins when both enables are raised together.
          bus.ramWEN = bus.dWEN;
          bus.ramREN = bus.dREN & ~bus.dWEN;
          if (ram_done) begin
            bus.dwait = 1'b0;
            state_d   = IDLE;
          end
        end
      end

      IGRANT: begin
        bus.ramaddr = bus.iaddr;
        if (!bus.iREN) begin
          state_d = IDLE;
        end else begin
          bus.ramREN = 1'b1;
          if (ram_done) begin
            bus.iwait = 1'b0;
            state_d   = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Load data is shared by both requesters; wait qualifies who may use it.
  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;

  // Grant register (and fairness counter when built).
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
`ifdef MEM_ARB_FAIR_EN
      dstreak_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
`ifdef MEM_ARB_FAIR_EN
      dstreak_q <= dstreak_d;
`endif
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_arbiter
// Directed scenarios for reset, ifetch, contention, withdrawal, ERROR retry
// and fairness, followed by randomized traffic compared against a port-owner
// reference model. Inputs change 1 time unit after the rising edge; outputs
// are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_memory_arbiter;

  localparam int unsigned W    = 32;
  localparam int          MAXS = 4;
  localparam logic [1:0]  FREE   = 2'd0;
  localparam logic [1:0]  BUSY   = 2'd1;
  localparam logic [1:0]  ACCESS = 2'd2;
  localparam logic [1:0]  ERROR  = 2'd3;
`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic CLK;
  logic nRST;
  int   chk_cnt;
  int   pass_cnt;

  memory_arbiter_if #(.WORD_W(W)) bus ();

  memory_arbiter #(.WORD_W(W), .MAX_DSTREAK(MAXS)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {ramREN, ramWEN, iwait, dwait}
  function automatic logic [3:0] ctl();
    return {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet();
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.ramstate = FREE;
    tick();
    tick();
  endtask

  task automatic test_reset();
    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0; bus.ramload = '0;
    bus.ramstate = FREE;
    nRST = 1'b0;
    #3;
    chk_cnt++;
    if ({ctl(), bus.ramaddr, bus.ramstore} !== {4'b0011, 64'd0})
      $display("FAIL reset_idle: got ctl=%b addr=%h store=%h expected ctl=0011 addr=0 store=0",
               ctl(), bus.ramaddr, bus.ramstore);
    else pass_cnt++;
    @(posedge CLK); #1 nRST = 1'b1;
    tick();
    // Reach DGRANT with the RAM busy, then pull reset.
    bus.dREN = 1'b1; bus.daddr = 32'h0000_1234; bus.ramstate = BUSY;
    tick();
    @(negedge CLK);
    chk_cnt++;
    if (ctl() !== 4'b1011) $display("FAIL reset_pre_dgrant: got %b expected 1011", ctl());
    else pass_cnt++;
    #1 nRST = 1'b0;
    #1;
    chk_cnt++;
    if ({ctl(), bus.ramaddr} !== {4'b0011, 32'd0})
      $display("FAIL reset_async: got ctl=%b addr=%h expected ctl=0011 addr=0", ctl(), bus.ramaddr);
    else pass_cnt++;
    @(posedge CLK); #1 nRST = 1'b1;
    // dREN still high: an IDLE state shows no RAM enable this cycle.
    @(negedge CLK);
    chk_cnt++;
    if (ctl() !== 4'b0011) $display("FAIL reset_to_idle: got %b expected 0011", ctl());
    else pass_cnt++;
    quiet();
  endtask

  task automatic test_ifetch();
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = FREE;
    @(negedge CLK);
    chk_cnt++;
    if (ctl() !== 4'b0011) $display("FAIL ifetch_latency: got %b expected 0011", ctl());
    else pass_cnt++;
    tick();
    bus.ramstate = BUSY;
    @(negedge CLK);
    chk_cnt++;
    if ({ctl(), bus.ramaddr} !== {4'b1011, 32'h40})
      $display("FAIL ifetch_grant: got ctl=%b addr=%h expected ctl=1011 addr=40", ctl(), bus.ramaddr);
    else pass_cnt++;
    tick();
    bus.ramstate = ACCESS; bus.ramload = 32'h2002_000A;
    @(negedge CLK);
    chk_cnt++;
    if ({ctl(), bus.iload} !== {4'b1001, 32'h2002_000A})
      $display("FAIL ifetch_done: got ctl=%b iload=%h expected ctl=1001 iload=2002000a", ctl(), bus.iload);
    else pass_cnt++;
    tick();
    bus.ramstate = FREE;
    @(negedge CLK);
    chk_cnt++;
    if (ctl() !== 4'b0011) $display("FAIL ifetch_one_cycle: got %b expected 0011", ctl());
    else pass_cnt++;
    quiet();
  endtask

  task automatic test_contention();
    bus.iREN = 1'b1; bus.iaddr = 32'h44;
    bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'hDEAD_BEEF;
    bus.ramstate = FREE;
    tick();
    bus.ramstate = BUSY;
    @(negedge CLK);
    chk_cnt++;
    if ({ctl(), bus.ramaddr, bus.ramstore} !== {4'b0111, 32'h80, 32'hDEAD_BEEF})
      $display("FAIL cont_dwrite: got ctl=%b addr=%h store=%h expected ctl=0111 addr=80 store=deadbeef",
               ctl(), bus.ramaddr, bus.ramstore);
    else pass_cnt++;
    tick();
    bus.ramstate = ACCESS;
    @(negedge CLK);
    chk_cnt++;
    if (ctl() !== 4'b0110) $display("FAIL cont_ddone: got %b expected 0110", ctl());
    else pass_cnt++;
    tick();
    bus.dWEN = 1'b0; bus.ramstate = FREE;
    @(negedge CLK);
    chk_cnt++;
    if (ctl() !== 4'b0011) $display("FAIL cont_bubble: got %b expected 0011", ctl());
    else pass_cnt++;
    tick();
    bus.ramstate = ACCESS;
    @(negedge CLK);
    chk_cnt++;
    if ({ctl(), bus.ramaddr, bus.ramstore} !== {4'b1001, 32'h44, 32'h0})
      $display("FAIL cont_ifetch: got ctl=%b addr=%h store=%h expected ctl=1001 addr=44 store=0",
               ctl(), bus.ramaddr, bus.ramstore);
    else pass_cnt++;
    tick();
    quiet();
  endtask

  task automatic test_withdrawal();
    bus.dREN = 1'b1; bus.daddr = 32'h10; bus.ramstate = BUSY;
    tick();
    @(negedge CLK);
    chk_cnt++;
    if (ctl() !== 4'b1011) $display("FAIL wd_grant: got %b expected 1011", ctl());
    else pass_cnt++;
    tick();
    bus.dREN = 1'b0;
    @(negedge CLK);
    chk_cnt++;
    if (ctl() !== 4'b0011) $display("FAIL wd_drop: got %b expected 0011", ctl());
    else pass_cnt++;
    tick();
    bus.dREN = 1'b1;
    @(negedge CLK);
    chk_cnt++;
    if (ctl() !== 4'b0011) $display("FAIL wd_idle_next: got %b expected 0011", ctl());
    else pass_cnt++;
    quiet();
  endtask

  task automatic test_error();
    bus.dREN = 1'b1; bus.daddr = 32'h99; bus.ramstate = ERROR;
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk_cnt++;
      if (ctl() !== 4'b1011) $display("FAIL error_hold%0d: got %b expected 1011", k, ctl());
      else pass_cnt++;
      tick();
    end
    bus.ramstate = ACCESS;
    @(negedge CLK);
    chk_cnt++;
    if (ctl() !== 4'b1010) $display("FAIL error_done: got %b expected 1010", ctl());
    else pass_cnt++;
    tick();
    bus.ramstate = FREE;
    @(negedge CLK);
    chk_cnt++;
    if (ctl() !== 4'b0011) $display("FAIL error_bubble: got %b expected 0011", ctl());
    else pass_cnt++;
    quiet();
  endtask

  task automatic test_fairness();
    int got[$];
    int exp;
    bus.dREN = 1'b1; bus.iREN = 1'b1; bus.ramstate = ACCESS;
    for (int c = 0; c < 50; c++) begin
      @(negedge CLK);
      if (bus.dwait === 1'b0) got.push_back(1);
      if (bus.iwait === 1'b0) got.push_back(2);
      tick();
    end
    chk_cnt++;
    if (got.size() < 20) $display("FAIL fair_count: got %0d completions expected at least 20", got.size());
    else pass_cnt++;
    for (int i = 0; i < 20 && i < got.size(); i++) begin
      exp = (FAIR && (i % (MAXS + 1) == MAXS)) ? 2 : 1;
      chk_cnt++;
      if (got[i] !== exp) $display("FAIL fair_order%0d: got requester %0d expected %0d", i, got[i], exp);
      else pass_cnt++;
    end
    quiet();
  endtask

  task automatic test_random();
    int owner, nxt, streak, nstreak;
    logic [3:0]   e_ctl;
    logic [W-1:0] e_addr, e_store;
    bit chk_a, d_want, acc;
    owner = 0; streak = 0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 4) == 0) bus.iREN = ~bus.iREN;
      if ($urandom_range(0, 4) == 0) bus.dREN = ~bus.dREN;
      if ($urandom_range(0, 7) == 0) bus.dWEN = ~bus.dWEN;
      bus.iaddr = $urandom(); bus.daddr = $urandom();
      bus.dstore = $urandom(); bus.ramload = $urandom();
      bus.ramstate = 2'($urandom_range(0, 3));

      // Reference: who owns the port and what it asks for this cycle.
      d_want = bus.dREN || bus.dWEN;
      acc    = (bus.ramstate == ACCESS);
      e_ctl = 4'b0011; e_addr = '0; e_store = '0; chk_a = 1;
      nxt = owner; nstreak = streak;
      if (owner == 0) begin
        if (!bus.iREN) nstreak = 0;
        if (d_want && !(FAIR && bus.iREN && streak >= MAXS)) begin
          nxt = 1;
          if (bus.iREN && streak < MAXS) nstreak = streak + 1;
        end else if (bus.iREN) begin
          nxt = 2; nstreak = 0;
        end else nxt = 0;
      end else if (owner == 1) begin
        if (!d_want) begin
          nxt = 0; chk_a = 0;
        end else begin
          e_ctl = {bus.dREN && !bus.dWEN, bus.dWEN, 1'b1, !acc};
          e_addr = bus.daddr; e_store = bus.dstore;
          if (acc) nxt = 0;
        end
      end else begin
        if (!bus.iREN) begin
          nxt = 0; chk_a = 0;
        end else begin
          e_ctl = {2'b10, !acc, 1'b1};
          e_addr = bus.iaddr;
          if (acc) nxt = 0;
        end
      end

      @(negedge CLK);
      chk_cnt++;
      if (ctl() !== e_ctl) $display("FAIL rand_ctl@%0d: got %b expected %b", c, ctl(), e_ctl);
      else pass_cnt++;
      if (chk_a) begin
        chk_cnt++;
        if ({bus.ramaddr, bus.ramstore} !== {e_addr, e_store})
          $display("FAIL rand_addr@%0d: got addr=%h store=%h expected addr=%h store=%h",
                   c, bus.ramaddr, bus.ramstore, e_addr, e_store);
        else pass_cnt++;
      end
      chk_cnt++;
      if ({bus.iload, bus.dload} !== {bus.ramload, bus.ramload})
        $display("FAIL rand_load@%0d: got i=%h d=%h expected %h", c, bus.iload, bus.dload, bus.ramload);
      else pass_cnt++;
      tick();
      owner = nxt; streak = nstreak;
    end
    quiet();
  endtask

  initial begin
    chk_cnt = 0;
    pass_cnt = 0;
    test_reset();
    test_ifetch();
    test_contention();
    test_withdrawal();
    test_error();
    test_fairness();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
